// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer ramp encoder: default sizes,
// FSM state encoding and the level-to-thermometer conversion.
package thermo_pkg;

  localparam int N_LEVELS_DEF = 15;
  localparam int BIN_W_DEF    = 4;

  // Widest thermometer code / level argument the helper can produce.
  localparam int THERM_MAX_W  = 64;
  localparam int LVL_ARG_W    = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  // Bits [lvl-1:0] set, all others clear; callers truncate to their width.
  function automatic logic [THERM_MAX_W-1:0] bin_to_therm(input logic [LVL_ARG_W-1:0] lvl);
    logic [THERM_MAX_W-1:0] t;
    t = {THERM_MAX_W{1'b0}};
    for (int i = 0; i < THERM_MAX_W; i++) begin
      t[i] = (LVL_ARG_W'(i) < lvl);
    end
    return t;
  endfunction

endpackage

// File: rtl/thermo_level_ctr.sv
// Saturating up/down level counter with a registered thermometer image.
// The thermometer register is loaded from the next level so it always
// matches the level register exactly (no bubbles, no wrap at either end).
module thermo_level_ctr
  import thermo_pkg::*;
#(
  parameter int N_LEVELS = N_LEVELS_DEF,
  parameter int LVL_W    = $clog2(N_LEVELS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [LVL_W-1:0]    load_val,
  input  logic                step_up,
  input  logic                step_dn,
  output logic [LVL_W-1:0]    level,
  output logic [N_LEVELS-1:0] therm
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(N_LEVELS);

  logic [LVL_W-1:0]    level_q, level_d;
  logic [N_LEVELS-1:0] therm_q, therm_d;

  // Next level: load wins, otherwise a single saturating step.
  always_comb begin
    level_d = level_q;
    if (load_en) begin
      level_d = load_val;
    end else if (step_up) begin
      if (level_q < LVL_MAX) begin
        level_d = level_q + LVL_W'(1);
      end else begin
        level_d = level_q;
      end
    end else if (step_dn) begin
      if (level_q != LVL_W'(0)) begin
        level_d = level_q - LVL_W'(1);
      end else begin
        level_d = level_q;
      end
    end else begin
      level_d = level_q;
    end
  end

  // Thermometer image of the next level, so out tracks L on the same edge.
  always_comb begin
    therm_d = N_LEVELS'(bin_to_therm(LVL_ARG_W'(level_d)));
  end

  // Level and thermometer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= LVL_W'(0);
      therm_q <= {N_LEVELS{1'b0}};
    end else begin
      level_q <= level_d;
      therm_q <= therm_d;
    end
  end

  assign level = level_q;
  assign therm = therm_q;

endmodule

// File: rtl/thermo_ramp_encoder.sv
// Binary-to-thermometer encoder with optional slew limiting.
// Optional feature macro: THERMO_SLEW_LIMIT_EN
//   defined   : a new target is approached one level per cycle (RAMP state)
//   undefined : a new target is loaded immediately, one transfer per cycle
module thermo_ramp_encoder
  import thermo_pkg::*;
#(
  parameter int N_LEVELS = N_LEVELS_DEF,
  parameter int BIN_W    = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic [N_LEVELS-1:0] out,
  output logic                out_valid,
  output logic                busy
);

  localparam int LVL_W = $clog2(N_LEVELS + 1);
  localparam int CMP_W = (BIN_W > LVL_W) ? BIN_W : LVL_W;
  localparam logic [CMP_W-1:0] N_CMP = CMP_W'(N_LEVELS);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [CMP_W-1:0] bin_ext;
  logic [LVL_W-1:0] tgt;
  logic [LVL_W-1:0] level;
  logic             load_en;
  logic [LVL_W-1:0] load_val;
  logic             step_up;
  logic             step_dn;

  // Clamp the incoming target to the top level before anything else sees it.
  always_comb begin
    bin_ext = CMP_W'(in_bin);
    if (bin_ext > N_CMP) begin
      tgt = LVL_W'(N_CMP);
    end else begin
      tgt = LVL_W'(bin_ext);
    end
  end

`ifdef THERMO_SLEW_LIMIT_EN
  logic [LVL_W-1:0] target_q, target_d;

  // Next-state logic: IDLE accepts targets, RAMP walks L one step per cycle.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    out_valid_d = 1'b0;
    load_en     = 1'b0;
    load_val    = tgt;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (tgt == level) begin
            out_valid_d = 1'b1;
          end else begin
            state_d  = ST_RAMP;
            target_d = tgt;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (target_q > level) begin
          step_up = 1'b1;
          if (target_q == level + LVL_W'(1)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end else if (target_q < level) begin
          step_dn = 1'b1;
          if (target_q == level - LVL_W'(1)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          // Cannot occur from IDLE entry; recover quietly.
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ramp target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= LVL_W'(0);
    end else begin
      target_q <= target_d;
    end
  end
`else
  // Direct load: every transfer sets L at once and is acknowledged next cycle.
  always_comb begin
    state_d     = ST_IDLE;
    load_en     = in_valid && (tgt != level);
    load_val    = tgt;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    out_valid_d = in_valid;
  end
`endif

  // FSM state and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  thermo_level_ctr #(
    .N_LEVELS (N_LEVELS),
    .LVL_W    (LVL_W)
  ) u_level_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .load_val (load_val),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .level    (level),
    .therm    (out)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RAMP);
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_thermo_ramp_encoder.sv
// Directed bench for thermo_ramp_encoder: a 15-level instance (a) and a
// 13-level instance (b) for clamp/saturation. Works with or without
// THERMO_SLEW_LIMIT_EN defined.
module tb_thermo_ramp_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_a, in_ready_a, out_valid_a, busy_a;
  logic [3:0]  in_bin_a;
  logic [14:0] out_a;
  logic        in_valid_b, in_ready_b, out_valid_b, busy_b;
  logic [3:0]  in_bin_b;
  logic [12:0] out_b;

  int total = 0;
  int bad   = 0;
  int pulses;

  always #5 clk = ~clk;

  thermo_ramp_encoder #(.N_LEVELS(15), .BIN_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_bin(in_bin_a), .out(out_a), .out_valid(out_valid_a), .busy(busy_a)
  );

  thermo_ramp_encoder #(.N_LEVELS(13), .BIN_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_bin(in_bin_b), .out(out_b), .out_valid(out_valid_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] th(input int k);
    logic [31:0] one;
    one = 32'd1;
    return (one << k) - 32'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] eo, input logic eov, input logic ebz);
    check_eq({tag, ".out"},  {17'd0, out_a}, eo);
    check_eq({tag, ".ov"},   {31'd0, out_valid_a}, {31'd0, eov});
    check_eq({tag, ".busy"}, {31'd0, busy_a}, {31'd0, ebz});
    check_eq({tag, ".rdy"},  {31'd0, in_ready_a}, {31'd0, !ebz});
  endtask

  task automatic check_b(input string tag, input logic [31:0] eo, input logic eov, input logic ebz);
    check_eq({tag, ".out"},  {19'd0, out_b}, eo);
    check_eq({tag, ".ov"},   {31'd0, out_valid_b}, {31'd0, eov});
    check_eq({tag, ".busy"}, {31'd0, busy_b}, {31'd0, ebz});
    check_eq({tag, ".rdy"},  {31'd0, in_ready_b}, {31'd0, !ebz});
  endtask

  task automatic xfer_a(input logic [3:0] v);
    in_valid_a = 1'b1;
    in_bin_a   = v;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic xfer_b(input logic [3:0] v);
    in_valid_b = 1'b1;
    in_bin_b   = v;
    tick();
    in_valid_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_bin_a = 4'd0;
    in_valid_b = 1'b0; in_bin_b = 4'd0;
    #2;
    check_eq("rst.out_a",  {17'd0, out_a}, 32'd0);
    check_eq("rst.ov_a",   {31'd0, out_valid_a}, 32'd0);
    check_eq("rst.busy_a", {31'd0, busy_a}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_a("rel_a", 32'd0, 1'b0, 1'b0);
    check_b("rel_b", 32'd0, 1'b0, 1'b0);

`ifdef THERMO_SLEW_LIMIT_EN
    // 0 -> 3: three single steps, then one pulse
    xfer_a(4'd3);
    check_a("up3_acc", 32'd0, 1'b0, 1'b1);
    tick(); check_a("up3_s1", 32'h1, 1'b0, 1'b1);
    tick(); check_a("up3_s2", 32'h3, 1'b0, 1'b1);
    tick(); check_a("up3_s3", 32'h7, 1'b1, 1'b0);
    tick(); check_a("up3_post", 32'h7, 1'b0, 1'b0);

    // Target equal to current level: immediate acknowledge, no ramp
    xfer_a(4'd3);
    check_a("eq3", 32'h7, 1'b1, 1'b0);
    tick(); check_a("eq3_post", 32'h7, 1'b0, 1'b0);

    // Up to 6 for the downward test
    xfer_a(4'd6);
    check_a("up6_acc", 32'h7, 1'b0, 1'b1);
    for (int k = 4; k <= 6; k++) begin
      tick(); check_a("up6", th(k), (k == 6), (k != 6));
    end
    tick();

    // 6 -> 1 with a competing in_valid=9 during the ramp
    in_valid_a = 1'b1;
    in_bin_a   = 4'd1;
    tick();
    check_a("dn1_acc", th(6), 1'b0, 1'b1);
    in_bin_a = 4'd9;
    for (int k = 5; k >= 1; k--) begin
      if (k == 2) in_valid_a = 1'b0;
      tick(); check_a("dn1", th(k), (k == 1), (k != 1));
    end
    tick(); check_a("dn1_post", 32'h1, 1'b0, 1'b0);

    // Reset at L=4 of a ramp to 10
    xfer_a(4'd10);
    check_a("r10_acc", 32'h1, 1'b0, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      tick(); check_a("r10", th(k), 1'b0, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check_eq("rmid.out",  {17'd0, out_a}, 32'd0);
    check_eq("rmid.ov",   {31'd0, out_valid_a}, 32'd0);
    check_eq("rmid.busy", {31'd0, busy_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); check_a("rmid_rel", 32'd0, 1'b0, 1'b0);
    tick(); check_a("rmid_rel2", 32'd0, 1'b0, 1'b0);

    // 13-level instance: 15 clamps to 13, saturates, then ramps down without wrap
    xfer_b(4'd15);
    check_b("clamp_acc", 32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      tick(); check_b("clamp_up", th(k), (k == 13), (k != 13));
    end
    tick(); check_b("sat_hold", 32'h1FFF, 1'b0, 1'b0);
    xfer_b(4'd15);
    check_b("sat_eq", 32'h1FFF, 1'b1, 1'b0);
    xfer_b(4'd0);
    check_b("dn0_acc", 32'h1FFF, 1'b0, 1'b1);
    for (int k = 12; k >= 0; k--) begin
      tick(); check_b("clamp_dn", th(k), (k == 0), (k != 0));
    end
    tick(); check_b("no_wrap", 32'd0, 1'b0, 1'b0);
`else
    // Back-to-back targets 2, 15, 0
    pulses = 0;
    in_valid_a = 1'b1;
    in_bin_a = 4'd2;
    tick(); check_a("b2b_2", 32'h3, 1'b1, 1'b0);
    if (out_valid_a) pulses++;
    in_bin_a = 4'd15;
    tick(); check_a("b2b_15", 32'h7FFF, 1'b1, 1'b0);
    if (out_valid_a) pulses++;
    in_bin_a = 4'd0;
    tick(); check_a("b2b_0", 32'd0, 1'b1, 1'b0);
    if (out_valid_a) pulses++;
    in_valid_a = 1'b0;
    tick(); check_a("b2b_post", 32'd0, 1'b0, 1'b0);
    if (out_valid_a) pulses++;
    check_eq("b2b_pulses", pulses, 32'd3);

    // Target equal to current level
    xfer_a(4'd3);
    check_a("ld3", 32'h7, 1'b1, 1'b0);
    xfer_a(4'd3);
    check_a("eq3", 32'h7, 1'b1, 1'b0);
    tick(); check_a("eq3_post", 32'h7, 1'b0, 1'b0);

    // Reset after loading 10
    xfer_a(4'd10);
    check_a("ld10", th(10), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rmid.out", {17'd0, out_a}, 32'd0);
    check_eq("rmid.ov",  {31'd0, out_valid_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); check_a("rmid_rel", 32'd0, 1'b0, 1'b0);

    // 13-level instance: clamp and no wrap
    xfer_b(4'd15);
    check_b("clamp", 32'h1FFF, 1'b1, 1'b0);
    tick(); check_b("sat_hold", 32'h1FFF, 1'b0, 1'b0);
    xfer_b(4'd0);
    check_b("ld0", 32'd0, 1'b1, 1'b0);
    tick(); check_b("no_wrap", 32'd0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thermo_ramp_encoder.md
THERMO_RAMP_ENCODER -- requirements
Module: thermo_ramp_encoder

Interface
REQ-001 SHALL have parameter N_LEVELS, default 15, meaning the thermometer output width (number of levels).
REQ-002 SHALL have parameter BIN_W, default 4, meaning the binary input width.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning in_bin carries a target level.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts a target this cycle.
REQ-007 SHALL have port in_bin, input, BIN_W bits, meaning the unsigned target level.
REQ-008 SHALL have port out, output, N_LEVELS bits, meaning the registered thermometer code (bits [L-1:0] set for level L).
REQ-009 SHALL have port out_valid, output, 1 bit, meaning a one-cycle pulse when out first equals the accepted target.
REQ-010 SHALL have port busy, output, 1 bit, meaning a ramp is in progress.

Function
REQ-011 SHALL perform a transfer on a rising clk edge when in_valid and in_ready are both 1.
REQ-012 SHALL clamp targets above N_LEVELS to N_LEVELS before any other processing.
REQ-013 SHALL keep an internal level counter L in 0..N_LEVELS, with out equal to the thermometer code of L at all times.
REQ-014 SHALL implement the states IDLE and RAMP, with in_ready = 1 only in IDLE and busy = 1 only in RAMP.
REQ-015 SHALL, on a transfer whose target equals L, stay in IDLE and assert out_valid on the next cycle with out unchanged.
REQ-016 SHALL, on a transfer whose target differs from L, behave as defined by REQ-024/REQ-025.
REQ-017 SHALL, in RAMP, change L by exactly 1 per cycle toward the target (up or down).
REQ-018 SHALL, on the cycle L reaches the target, return to IDLE and pulse out_valid for 1 cycle.
REQ-019 SHALL ignore in_valid during RAMP; in_bin need not be held stable.
REQ-020 SHALL never produce a non-thermometer (bubbled) out value, including at the 0 and N_LEVELS boundaries.
REQ-021 SHALL not wrap L: it saturates at 0 and at N_LEVELS.

Reset
REQ-022 SHALL, while rst_n = 0 (asynchronously), force state = IDLE, L = 0, out = 0, out_valid = 0 and busy = 0, with in_ready = 1 from the first edge after release.
REQ-023 SHALL, on reset asserted mid-ramp, abandon the ramp immediately with no out_valid pulse.

Configuration
REQ-024 SHALL, with macro THERMO_SLEW_LIMIT_EN defined, enter RAMP on a transfer with target different from L and step per REQ-017; latency is |target−L| cycles to out_valid.
REQ-025 SHALL, without THERMO_SLEW_LIMIT_EN, load L = target on the transfer edge, pulse out_valid on the next cycle, never enter RAMP, and hold busy = 0 and in_ready = 1 permanently (one transfer per cycle).

Structure
REQ-026 SHALL place N_LEVELS/BIN_W defaults, the IDLE/RAMP state enum and a bin-to-thermometer function in the shared package thermo_pkg.
REQ-027 SHALL implement the saturating up/down level counter as sub-module thermo_level_ctr; the FSM and handshake live in the top.

Verification
REQ-028 SHALL verify reset release: out = 15'b0, in_ready = 1, busy = 0, out_valid = 0.
REQ-029 SHALL verify, with the slew macro, target 3 from L = 0: out steps through 000...001, 000...011 and 000...111 over 3 cycles, then out_valid pulses once and in_ready returns to 1.
REQ-030 SHALL verify, with the slew macro, target 1 from L = 6: out steps 6→5→4→3→2→1 over 5 cycles, and an in_valid with value 9 during the ramp is ignored.
REQ-031 SHALL verify that target equal to the current L (e.g. 3 at L = 3) gives out_valid the next cycle, no RAMP and no change on out.
REQ-032 SHALL verify clamp and saturation: N_LEVELS = 13, in_bin = 15 ends with out = all 13 bits set and L = 13; a following target of 0 ramps down to 13'b0 with no wrap.
REQ-033 SHALL verify that rst_n pulsed low at L = 4 of a ramp to 10 gives out = 0 immediately, no out_valid, and in_ready = 1 after release.
REQ-034 SHALL verify, without the slew macro, back-to-back targets 2, 15 and 0 on consecutive cycles: out is the matching codes one cycle later each, with 3 out_valid pulses.
